// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - RV32I opcode, ALU, immediate-select and control encodings plus the control decoder
// Optional feature macro: DECODE_MEXT_EN (R-type funct7=0x01 funct3=000 decodes as MUL).
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SLL    = 4'b0011;
  localparam logic [3:0] ALU_SUB    = 4'b0100;
  localparam logic [3:0] ALU_SRL    = 4'b0101;
  localparam logic [3:0] ALU_MUL    = 4'b0110;
  localparam logic [3:0] ALU_XOR    = 4'b0111;
  localparam logic [3:0] ALU_SLT    = 4'b1000;
  localparam logic [3:0] ALU_SRA    = 4'b1001;
  localparam logic [3:0] ALU_SLTU   = 4'b1010;
  localparam logic [3:0] ALU_PASS_B = 4'b1011;

  localparam logic       SRC_A_RS1 = 1'b0;
  localparam logic       SRC_A_PC  = 1'b1;
  localparam logic [1:0] SRC_B_RS2 = 2'b00;
  localparam logic [1:0] SRC_B_IMM = 2'b01;
  localparam logic [1:0] RES_ALU   = 2'b00;
  localparam logic [1:0] RES_MEM   = 2'b01;
  localparam logic [1:0] RES_PC4   = 2'b10;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_sel_t;

  typedef struct packed {
    logic [3:0] alu;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] result_src;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       illegal;
    logic       rs2_zero;
    imm_sel_t   imm_sel;
  } ctrl_t;

  // Shared by R-type (funct7=0x00) and OP-IMM
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic ctrl_t decode_ctrl(input logic [6:0] opcode, input logic [2:0] f3,
                                        input logic [6:0] f7);
    ctrl_t c;
    logic  bad;
    c   = '0;
    bad = 1'b0;
    case (opcode)
      OP_R: begin
        c.reg_write = 1'b1;
        if (f7 == 7'h00) c.alu = alu_from_f3(f3);
        else if (f7 == 7'h20 && f3 == 3'b000) c.alu = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'b101) c.alu = ALU_SRA;
`ifdef DECODE_MEXT_EN
        else if (f7 == 7'h01 && f3 == 3'b000) c.alu = ALU_MUL;
`endif
        else bad = 1'b1;
      end
      OP_IMM: begin
        c.reg_write = 1'b1;
        c.src_b     = SRC_B_IMM;
        c.imm_sel   = IMM_I;
        c.rs2_zero  = 1'b1;
        c.alu       = alu_from_f3(f3);
        if (f3 == 3'b001 && f7 != 7'h00) bad = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == 7'h20) c.alu = ALU_SRA;
          else if (f7 != 7'h00) bad = 1'b1;
        end
      end
      OP_LOAD: begin
        bad = (f3 != 3'b010);
        c.alu = ALU_ADD; c.src_b = SRC_B_IMM; c.result_src = RES_MEM;
        c.reg_write = 1'b1; c.imm_sel = IMM_I; c.rs2_zero = 1'b1;
      end
      OP_STORE: begin
        bad = (f3 != 3'b010);
        c.alu = ALU_ADD; c.src_b = SRC_B_IMM; c.mem_write = 1'b1; c.imm_sel = IMM_S;
      end
      OP_BRANCH: begin
        bad = (f3 == 3'b010 || f3 == 3'b011);
        c.alu = ALU_SUB; c.branch = 1'b1; c.imm_sel = IMM_B;
      end
      OP_JAL: begin
        c.alu = ALU_ADD; c.src_a = SRC_A_PC; c.src_b = SRC_B_IMM; c.result_src = RES_PC4;
        c.reg_write = 1'b1; c.jump = 1'b1; c.imm_sel = IMM_J; c.rs2_zero = 1'b1;
      end
      OP_JALR: begin
        bad = (f3 != 3'b000);
        c.alu = ALU_ADD; c.src_b = SRC_B_IMM; c.result_src = RES_PC4;
        c.reg_write = 1'b1; c.jump = 1'b1; c.imm_sel = IMM_I; c.rs2_zero = 1'b1;
      end
      OP_LUI: begin
        c.alu = ALU_PASS_B; c.src_b = SRC_B_IMM; c.reg_write = 1'b1;
        c.imm_sel = IMM_U; c.rs2_zero = 1'b1;
      end
      OP_AUIPC: begin
        c.alu = ALU_ADD; c.src_a = SRC_A_PC; c.src_b = SRC_B_IMM; c.reg_write = 1'b1;
        c.imm_sel = IMM_U; c.rs2_zero = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      c         = '0;
      c.illegal = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - RV32I immediate extraction, sign-extended to XLEN
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_sel_t        imm_sel,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    case (imm_sel)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      default: imm32 = '0;
    endcase
    imm       = {XLEN{imm32[31]}};
    imm[31:0] = imm32;
  end

endmodule

// File: rtl/instr_decode_queue.sv
// rtl/instr_decode_queue.sv - fetch-to-execute instruction queue with RV32I head decode
// Optional feature macro: DECODE_MEXT_EN (enables MUL decode in decode_pkg).
module instr_decode_queue
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [4:0]               out_rd,
  output logic [XLEN-1:0]          out_imm,
  output logic [3:0]               out_alu_ctrl,
  output logic                     out_alu_src_a,
  output logic [1:0]               out_alu_src_b,
  output logic [1:0]               out_result_src,
  output logic                     out_mem_write,
  output logic                     out_reg_write,
  output logic                     out_branch,
  output logic                     out_jump,
  output logic [2:0]               out_br_funct3,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count;
  logic            push, pop;

  assign in_ready  = (count != FULL_COUNT) && !flush;
  assign out_valid = (count != '0);
  assign occupancy = count;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage is deliberately left out of reset; out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wptr]    <= in_pc;
      instr_mem[wptr] <= in_instr;
    end
  end

  logic [31:0]     head;
  ctrl_t           ctrl;
  logic [XLEN-1:0] imm;

  assign head = instr_mem[rptr];
  assign ctrl = decode_ctrl(head[6:0], head[14:12], head[31:25]);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr   (head[31:7]),
    .imm_sel (ctrl.imm_sel),
    .imm     (imm)
  );

  always_comb begin
    out_pc         = '0;
    out_rs1        = '0;
    out_rs2        = '0;
    out_rd         = '0;
    out_imm        = '0;
    out_alu_ctrl   = '0;
    out_alu_src_a  = 1'b0;
    out_alu_src_b  = '0;
    out_result_src = '0;
    out_mem_write  = 1'b0;
    out_reg_write  = 1'b0;
    out_branch     = 1'b0;
    out_jump       = 1'b0;
    out_br_funct3  = '0;
    out_illegal    = 1'b0;
    if (out_valid) begin
      out_pc         = pc_mem[rptr];
      out_rs1        = head[19:15];
      out_rs2        = ctrl.rs2_zero ? 5'd0 : head[24:20];
      out_rd         = head[11:7];
      out_imm        = imm;
      out_alu_ctrl   = ctrl.alu;
      out_alu_src_a  = ctrl.src_a;
      out_alu_src_b  = ctrl.src_b;
      out_result_src = ctrl.result_src;
      out_mem_write  = ctrl.mem_write;
      out_reg_write  = ctrl.reg_write;
      out_branch     = ctrl.branch;
      out_jump       = ctrl.jump;
      out_br_funct3  = ctrl.branch ? head[14:12] : 3'b000;
      out_illegal    = ctrl.illegal;
    end
  end

endmodule

// File: tb/tb_instr_decode_queue.sv
// tb/tb_instr_decode_queue.sv - directed and random checks of instr_decode_queue against a queue/decoder model
module tb_instr_decode_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
`ifdef DECODE_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif
  localparam logic [3:0] ALU_F3 [8] = '{4'h2, 4'h3, 4'h8, 4'hA, 4'h7, 4'h5, 4'h1, 4'h0};
  localparam logic [6:0] OPS [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                      7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [XLEN-1:0] in_pc, out_pc, out_imm;
  logic [31:0] in_instr;
  logic [4:0] out_rs1, out_rs2, out_rd;
  logic [3:0] out_alu_ctrl;
  logic out_alu_src_a, out_mem_write, out_reg_write, out_branch, out_jump, out_illegal;
  logic [1:0] out_alu_src_b, out_result_src;
  logic [2:0] out_br_funct3;
  logic [$clog2(DEPTH):0] occupancy;

  always #5 clk = ~clk;

  instr_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_alu_ctrl(out_alu_ctrl), .out_alu_src_a(out_alu_src_a), .out_alu_src_b(out_alu_src_b),
    .out_result_src(out_result_src), .out_mem_write(out_mem_write),
    .out_reg_write(out_reg_write), .out_branch(out_branch), .out_jump(out_jump),
    .out_br_funct3(out_br_funct3), .out_illegal(out_illegal), .occupancy(occupancy)
  );

  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        src_a;
    logic [1:0]  src_b, res;
    logic        mw, rw, br, jp;
    logic [2:0]  bf3;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t mq[$];
  int total = 0;
  int bad = 0;
  int popped = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decoder: immediates from signed arithmetic shifts of the whole word
  function automatic exp_t ref_dec(input logic [31:0] w);
    exp_t e;
    exp_t ie;
    logic ok;
    int   sw;
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    sw = $signed(w);
    e = '0; ok = 1'b1;
    e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
    case (op)
      7'h33: begin
        e.rw = 1'b1;
        if (f7 == 7'h00) e.alu = ALU_F3[f3];
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) e.alu = (f3 == 3'd0) ? 4'h4 : 4'h9;
        else if (MEXT && f7 == 7'h01 && f3 == 3'd0) e.alu = 4'h6;
        else ok = 1'b0;
      end
      7'h13: begin
        e.rw = 1'b1; e.src_b = 2'b01; e.imm = sw >>> 20; e.rs2 = 5'd0;
        e.alu = ALU_F3[f3];
        if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
        if (f3 == 3'd5 && f7 == 7'h20) e.alu = 4'h9;
        else if (f3 == 3'd5 && f7 != 7'h00) ok = 1'b0;
      end
      7'h03: begin
        ok = (f3 == 3'd2); e.alu = 4'h2; e.src_b = 2'b01; e.res = 2'b01; e.rw = 1'b1;
        e.imm = sw >>> 20; e.rs2 = 5'd0;
      end
      7'h23: begin
        ok = (f3 == 3'd2); e.alu = 4'h2; e.src_b = 2'b01; e.mw = 1'b1;
        e.imm = ((sw >>> 25) <<< 5) | int'(w[11:7]);
      end
      7'h63: begin
        ok = (f3 != 3'd2 && f3 != 3'd3); e.alu = 4'h4; e.br = 1'b1; e.bf3 = f3;
        e.imm = ((sw >>> 31) <<< 12) | (int'(w[7]) << 11) | (int'(w[30:25]) << 5)
              | (int'(w[11:8]) << 1);
      end
      7'h6F: begin
        e.rw = 1'b1; e.jp = 1'b1; e.res = 2'b10; e.src_a = 1'b1; e.alu = 4'h2; e.src_b = 2'b01;
        e.imm = ((sw >>> 31) <<< 20) | (int'(w[19:12]) << 12) | (int'(w[20]) << 11)
              | (int'(w[30:21]) << 1);
        e.rs2 = 5'd0;
      end
      7'h67: begin
        ok = (f3 == 3'd0); e.rw = 1'b1; e.jp = 1'b1; e.res = 2'b10; e.alu = 4'h2;
        e.src_b = 2'b01; e.imm = sw >>> 20; e.rs2 = 5'd0;
      end
      7'h37: begin
        e.alu = 4'hB; e.src_b = 2'b01; e.rw = 1'b1; e.imm = w & 32'hFFFF_F000; e.rs2 = 5'd0;
      end
      7'h17: begin
        e.src_a = 1'b1; e.alu = 4'h2; e.src_b = 2'b01; e.rw = 1'b1;
        e.imm = w & 32'hFFFF_F000; e.rs2 = 5'd0;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      ie = '0;
      ie.rs1 = w[19:15]; ie.rs2 = w[24:20]; ie.rd = w[11:7]; ie.ill = 1'b1;
      e = ie;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    w[6:0] = OPS[$urandom_range(0, 9)];
    if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20;
    if ((w[6:0] == 7'h03 || w[6:0] == 7'h23) && $urandom_range(0, 1) == 1) w[14:12] = 3'd2;
    return w;
  endfunction

  // One clock: drive, check against the model, then advance the model at the edge
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                     input logic ordy, input logic fl);
    exp_t e;
    logic [31:0] epc;
    logic do_push, do_pop;
    ent_t n;
    in_valid = v; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
    #1;
    check("occupancy", 64'(occupancy), 64'(mq.size()));
    check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    check("in_ready", 64'(in_ready), 64'((mq.size() < DEPTH) && !fl));
    if (mq.size() != 0) begin
      e = ref_dec(mq[0].instr); epc = mq[0].pc;
    end else begin
      e = '0; epc = '0;
    end
    check("head_pc", 64'(out_pc), 64'(epc));
    check("regs", 64'({out_rs1, out_rs2, out_rd}), 64'({e.rs1, e.rs2, e.rd}));
    check("imm", 64'(out_imm), 64'(e.imm));
    check("ctrl", 64'({out_alu_ctrl, out_alu_src_a, out_alu_src_b, out_result_src, out_mem_write,
                       out_reg_write, out_branch, out_jump, out_br_funct3, out_illegal}),
                  64'({e.alu, e.src_a, e.src_b, e.res, e.mw, e.rw, e.br, e.jp, e.bf3, e.ill}));
    do_push = v && (mq.size() < DEPTH) && !fl;
    do_pop  = (mq.size() != 0) && ordy && !fl;
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (do_pop) begin
        void'(mq.pop_front());
        popped++;
      end
      if (do_push) begin
        n.pc = pc; n.instr = ins;
        mq.push_back(n);
      end
    end
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 4 * DEPTH && mq.size() != 0; k++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("drain_empty", 64'(mq.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    logic [31:0] pc;
    logic v;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_instr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_occupancy", 64'(occupancy), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    rst = 1'b0;

    // ADD x3,x1,x2 visible the cycle after the push edge
    cyc(1'b1, 32'h100, 32'h002081B3, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    check("add_valid", 64'(out_valid), 64'(1));
    check("add_alu", 64'(out_alu_ctrl), 64'(4'b0010));
    check("add_regw", 64'(out_reg_write), 64'(1));
    check("add_regs", 64'({out_rs1, out_rs2, out_rd}), 64'({5'd1, 5'd2, 5'd3}));
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill to DEPTH, offer one more while full, then pop one
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'h200 + 32'(4 * i), rand_instr(), 1'b0, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'(0));
    check("full_occupancy", 64'(occupancy), 64'(DEPTH));
    cyc(1'b1, 32'h300, rand_instr(), 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("after_pop_in_ready", 64'(in_ready), 64'(1));
    check("after_pop_occupancy", 64'(occupancy), 64'(DEPTH - 1));
    drain();

    // Random stream across pointer wrap with out_ready toggling
    popped = 0; sent = 0; pc = 32'h1000;
    for (int k = 0; k < 400 && sent < 3 * DEPTH; k++) begin
      v = ($urandom_range(0, 3) != 0);
      if (v && mq.size() < DEPTH) begin
        cyc(v, pc, rand_instr(), 1'($urandom_range(0, 1)), 1'b0);
        sent++; pc += 4;
      end else begin
        cyc(v, pc, rand_instr(), 1'($urandom_range(0, 1)), 1'b0);
      end
    end
    check("stream_sent", 64'(sent), 64'(3 * DEPTH));
    drain();
    check("stream_popped", 64'(popped), 64'(3 * DEPTH));

    // Flush with three queued entries and a word offered in the same cycle
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h400 + 32'(4 * i), rand_instr(), 1'b0, 1'b0);
    cyc(1'b1, 32'h500, 32'h002081B3, 1'b1, 1'b1);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_occupancy", 64'(occupancy), 64'(0));
    check("flush_out_valid", 64'(out_valid), 64'(0));
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // BEQ x0,x0,-8
    cyc(1'b1, 32'h600, 32'hFE000CE3, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    check("beq_branch", 64'(out_branch), 64'(1));
    check("beq_alu", 64'(out_alu_ctrl), 64'(4'b0100));
    check("beq_imm", 64'(out_imm), 64'(32'hFFFF_FFF8));
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // SW x5,-4(x2)
    cyc(1'b1, 32'h604, 32'hFE512E23, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    check("sw_mem_write", 64'(out_mem_write), 64'(1));
    check("sw_reg_write", 64'(out_reg_write), 64'(0));
    check("sw_imm", 64'(out_imm), 64'(32'hFFFF_FFFC));
    check("sw_rs", 64'({out_rs1, out_rs2}), 64'({5'd2, 5'd5}));
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // MUL x3,x1,x2
    cyc(1'b1, 32'h608, 32'h022081B3, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    check("mul_illegal", 64'(out_illegal), 64'(!MEXT));
    check("mul_alu", 64'(out_alu_ctrl), MEXT ? 64'(4'b0110) : 64'(4'b0000));
    check("mul_regw", 64'(out_reg_write), 64'(MEXT));
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Unsupported opcode 0x7F
    cyc(1'b1, 32'h60C, 32'h0000007F, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    check("op7f_illegal", 64'(out_illegal), 64'(1));
    check("op7f_strobes", 64'({out_mem_write, out_reg_write, out_branch, out_jump, out_alu_ctrl}),
          64'(0));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
